// File: rtl/two_pulse_generator_pkg.sv
// Shared types and constants for the two-cycle-wide increment pulse generator.
package two_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH1 = 2'd1,
        HIGH2 = 2'd2,
        GAPW  = 2'd3
    } state_e;

    localparam int unsigned PULSE_W = 2;
    localparam int unsigned CW_DEF  = 4;
    localparam int unsigned GAP_W   = 4;
    localparam int unsigned GAP_DEF = 1;
    localparam int unsigned SENT_W  = 4;

endpackage

// File: rtl/two_pulse_generator_if.sv
// Request/pulse bus between a requester and the two-pulse generator.
// Optional sent_cnt signal present when TWO_PULSE_SENT_CNT_EN is defined.
interface two_pulse_generator_if
    import two_pulse_pkg::*;
#(
    parameter int unsigned CW = CW_DEF
);
    logic          req;
    logic          load;
    logic [CW-1:0] load_val;
    logic          clr_ovf;
    logic          inc;
    logic          busy;
    logic [CW-1:0] pending;
    logic          done;
    logic          overflow;
`ifdef TWO_PULSE_SENT_CNT_EN
    logic [SENT_W-1:0] sent_cnt;
`endif

    modport master (
        output req, load, load_val, clr_ovf,
        input  inc, busy, pending, done, overflow
`ifdef TWO_PULSE_SENT_CNT_EN
        , input sent_cnt
`endif
    );

    modport slave (
        input  req, load, load_val, clr_ovf,
        output inc, busy, pending, done, overflow
`ifdef TWO_PULSE_SENT_CNT_EN
        , output sent_cnt
`endif
    );

endinterface

// File: rtl/two_pulse_generator_sat_updown_cnt.sv
// Saturating up/down counter with synchronous load; sat flags an increment lost at max.
module sat_updown_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         sat_c
);
    localparam logic [W-1:0] MAX = '1;

    assign sat_c = inc && !dec && !load && (count == MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && !dec) begin
            if (count != MAX) count <= count + W'(1);
        end else if (dec && !inc) begin
            if (count != '0) count <= count - W'(1);
        end
    end

endmodule

// File: rtl/two_pulse_generator.sv
// Turns request strobes or loaded bursts into 2-cycle-high inc pulses with a programmable gap.
// Optional sent_cnt output enabled by TWO_PULSE_SENT_CNT_EN.
module two_pulse_generator
    import two_pulse_pkg::*;
#(
    parameter int unsigned CW  = CW_DEF,
    parameter int unsigned GAP = GAP_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    two_pulse_generator_if.slave  bus
);
    localparam logic [GAP_W-1:0] GAP_M1 = (GAP == 0) ? '0 : GAP_W'(GAP - 1);

    state_e           state;
    logic [GAP_W-1:0] gap_cnt;
    logic [CW-1:0]    pending;
    logic             pend_nz_c;
    logic             busy_c;
    logic             load_acc_c;
    logic             req_acc_c;
    logic             start_c;
    logic             sat_c;

    assign pend_nz_c  = (pending != '0);
    assign busy_c     = (state != IDLE) || pend_nz_c;
    assign load_acc_c = bus.load && !busy_c && (bus.load_val != '0);
    assign req_acc_c  = bus.req && !load_acc_c;
    assign bus.busy    = busy_c;
    assign bus.pending = pending;

    // A pulse starts whenever the FSM is about to enter HIGH1.
    always_comb begin
        start_c = 1'b0;
        case (state)
            IDLE:    start_c = pend_nz_c;
            HIGH2:   start_c = pend_nz_c && (GAP == 0);
            GAPW:    start_c = pend_nz_c && (gap_cnt == '0);
            default: start_c = 1'b0;
        endcase
    end

    sat_updown_cnt #(.W(CW)) u_pending (
        .clk      (clk),
        .rst      (rst),
        .load     (load_acc_c),
        .load_val (bus.load_val),
        .inc      (req_acc_c),
        .dec      (start_c),
        .count    (pending),
        .sat_c    (sat_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            gap_cnt      <= '0;
            bus.inc      <= 1'b0;
            bus.done     <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            bus.inc  <= 1'b0;
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_c) begin
                        state   <= HIGH1;
                        bus.inc <= 1'b1;
                    end
                end
                HIGH1: begin
                    state   <= HIGH2;
                    bus.inc <= 1'b1;
                end
                HIGH2: begin
                    if (start_c) begin
                        state   <= HIGH1;
                        bus.inc <= 1'b1;
                    end else if (GAP != 0) begin
                        state   <= GAPW;
                        gap_cnt <= GAP_M1;
                    end else begin
                        state    <= IDLE;
                        bus.done <= 1'b1;
                    end
                end
                GAPW: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end else if (start_c) begin
                        state   <= HIGH1;
                        bus.inc <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        bus.done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // A fresh overflow beats a same-cycle clear.
            if (sat_c) bus.overflow <= 1'b1;
            else if (bus.clr_ovf) bus.overflow <= 1'b0;
        end
    end

`ifdef TWO_PULSE_SENT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) bus.sent_cnt <= '0;
        else if (state == HIGH2) bus.sent_cnt <= bus.sent_cnt + SENT_W'(1);
    end
`endif

endmodule

// File: tb/tb_two_pulse_generator.sv
// Self-checking bench: three generators (GAP=0,1,2) with a pulse scoreboard per instance.
module tb_two_pulse_generator;
    import two_pulse_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    two_pulse_generator_if #(.CW(4)) if0 ();
    two_pulse_generator_if #(.CW(4)) if1 ();
    two_pulse_generator_if #(.CW(4)) if2 ();

    two_pulse_generator #(.CW(4), .GAP(0)) u_g0 (.clk(clk), .rst(rst), .bus(if0));
    two_pulse_generator #(.CW(4), .GAP(1)) u_g1 (.clk(clk), .rst(rst), .bus(if1));
    two_pulse_generator #(.CW(4), .GAP(2)) u_g2 (.clk(clk), .rst(rst), .bus(if2));

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected pulse ids pushed at stimulus, popped per completed 2-cycle pulse.
    int   sb_q [3][$];
    int   pushed [3];
    int   seen [3];
    int   phase [3];
    bit   partial_ok [3];
    logic [2:0] inc_v;
    assign inc_v = {if2.inc, if1.inc, if0.inc};

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (inc_v[i] === 1'b1) begin
                if (phase[i] == 1) begin
                    int exp_id;
                    phase[i] = 0;
                    seen[i]++;
                    checks++;
                    if (sb_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected[%0d]: got pulse %0d, expected none", i, seen[i]);
                    end else begin
                        exp_id = sb_q[i].pop_front();
                        if (seen[i] !== exp_id) begin
                            errors++;
                            $display("FAIL sb_order[%0d]: got pulse %0d, expected %0d", i, seen[i], exp_id);
                        end
                    end
                end else begin
                    phase[i] = 1;
                end
            end else begin
                if (phase[i] == 1 && !partial_ok[i]) begin
                    checks++;
                    errors++;
                    $display("FAIL pulse_width[%0d]: got 1 high cycle, expected %0d", i, PULSE_W);
                end
                phase[i] = 0;
            end
        end
    end

    task automatic push_exp(input int i);
        pushed[i]++;
        sb_q[i].push_back(pushed[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({if0.inc, if1.inc, if2.inc} !== 3'b000) begin errors++; $display("FAIL reset_inc: got %b, expected 000", {if0.inc, if1.inc, if2.inc}); end
        checks++; if ({if0.busy, if1.busy, if2.busy} !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b, expected 000", {if0.busy, if1.busy, if2.busy}); end
        checks++; if ({if0.done, if1.done, if2.done} !== 3'b000) begin errors++; $display("FAIL reset_done: got %b, expected 000", {if0.done, if1.done, if2.done}); end
        checks++; if ({if0.overflow, if1.overflow, if2.overflow} !== 3'b000) begin errors++; $display("FAIL reset_ovf: got %b, expected 000", {if0.overflow, if1.overflow, if2.overflow}); end
        checks++; if ({if0.pending, if1.pending, if2.pending} !== 12'h000) begin errors++; $display("FAIL reset_pending: got %h, expected 000", {if0.pending, if1.pending, if2.pending}); end
`ifdef TWO_PULSE_SENT_CNT_EN
        checks++; if (if0.sent_cnt !== 4'd0) begin errors++; $display("FAIL reset_sent_cnt: got %0d, expected 0", if0.sent_cnt); end
`endif
        rst = 1'b0;
    endtask

    // req at cycle 5 on GAP=1: inc 7-8, low 9, done 10, busy 6-9.
    task automatic test_single_req();
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            checks++; if (if1.inc !== 1'(c == 7 || c == 8)) begin errors++; $display("FAIL single_inc c%0d: got %b, expected %b", c, if1.inc, (c == 7 || c == 8)); end
            checks++; if (if1.done !== 1'(c == 10)) begin errors++; $display("FAIL single_done c%0d: got %b, expected %b", c, if1.done, (c == 10)); end
            checks++; if (if1.busy !== 1'(c >= 6 && c <= 9)) begin errors++; $display("FAIL single_busy c%0d: got %b, expected %b", c, if1.busy, (c >= 6 && c <= 9)); end
            if1.req = (c == 5);
            if (c == 5) push_exp(1);
        end
    endtask

    // GAP=0 burst of 3 from load at cycle 2: inc 4..9, done 10.
    task automatic test_burst_gap0();
        int hi_cnt;
        int model_cnt;
        hi_cnt = 0;
        model_cnt = 0;
        for (int c = 0; c < 13; c++) begin
            @(posedge clk); #1;
            if (if0.inc === 1'b1) begin
                hi_cnt++;
                if (hi_cnt == PULSE_W) begin model_cnt++; hi_cnt = 0; end
            end else begin
                hi_cnt = 0;
            end
            checks++; if (if0.inc !== 1'(c >= 4 && c <= 9)) begin errors++; $display("FAIL burst_inc c%0d: got %b, expected %b", c, if0.inc, (c >= 4 && c <= 9)); end
            checks++; if (if0.done !== 1'(c == 10)) begin errors++; $display("FAIL burst_done c%0d: got %b, expected %b", c, if0.done, (c == 10)); end
            checks++; if (if0.busy !== 1'(c >= 3 && c <= 9)) begin errors++; $display("FAIL burst_busy c%0d: got %b, expected %b", c, if0.busy, (c >= 3 && c <= 9)); end
`ifdef TWO_PULSE_SENT_CNT_EN
            if (c == 10) begin
                checks++; if (if0.sent_cnt !== 4'd3) begin errors++; $display("FAIL burst_sent_cnt: got %0d, expected 3", if0.sent_cnt); end
            end
`endif
            if0.load     = (c == 2);
            if0.load_val = (c == 2) ? 4'd3 : 4'd0;
            if (c == 2) for (int k = 0; k < 3; k++) push_exp(0);
        end
        checks++; if (model_cnt !== 3) begin errors++; $display("FAIL burst_counter_model: got %0d, expected 3", model_cnt); end
    endtask

    // GAP=2 req stream: saturation at 15, req+start at 15 holds, then overflow.
    task automatic test_saturate();
        int c, hi_run, lo_run, pulses;
        bit seen_hi;
        c = 0; hi_run = 0; lo_run = 0; pulses = 0; seen_hi = 1'b0;
        while ((c < 25 || if2.busy === 1'b1) && c < 300) begin
            @(posedge clk); #1;
            if (c == 20 || c == 22 || c == 23) begin
                checks++; if (if2.pending !== 4'd15) begin errors++; $display("FAIL sat_pending c%0d: got %0d, expected 15", c, if2.pending); end
                checks++; if (if2.overflow !== 1'(c == 23)) begin errors++; $display("FAIL sat_overflow c%0d: got %b, expected %b", c, if2.overflow, (c == 23)); end
            end
            if (c == 22) begin
                checks++; if (if2.inc !== 1'b1) begin errors++; $display("FAIL sat_start_inc: got %b, expected 1", if2.inc); end
            end
            if (if2.inc === 1'b1) begin
                if (seen_hi && lo_run > 0) begin
                    checks++; if (lo_run !== 2) begin errors++; $display("FAIL sat_gap: got %0d low cycles, expected 2", lo_run); end
                end
                hi_run++; lo_run = 0; seen_hi = 1'b1;
            end else begin
                if (hi_run > 0) begin
                    pulses++;
                    checks++; if (hi_run !== int'(PULSE_W)) begin errors++; $display("FAIL sat_width: got %0d high cycles, expected %0d", hi_run, PULSE_W); end
                end
                hi_run = 0;
                if (seen_hi) lo_run++;
            end
            if2.req = (c <= 19 || c == 21 || c == 22);
            if (c <= 19 || c == 21) push_exp(2);
            c++;
        end
        if2.req = 1'b0;
        checks++; if (c >= 300) begin errors++; $display("FAIL sat_timeout: got %0d cycles, expected idle before 300", c); end
        checks++; if (pulses !== 21) begin errors++; $display("FAIL sat_pulses: got %0d, expected 21", pulses); end
    endtask

    task automatic test_clr_ovf();
        @(posedge clk); #1;
        checks++; if (if2.overflow !== 1'b1) begin errors++; $display("FAIL clr_pre: got %b, expected 1", if2.overflow); end
        if2.clr_ovf = 1'b1;
        @(posedge clk); #1;
        if2.clr_ovf = 1'b0;
        checks++; if (if2.overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b, expected 0", if2.overflow); end
    endtask

    // Load with same-cycle req, then ignored load of 9 while busy.
    task automatic test_load_busy();
        int c, dones;
        if1.load = 1'b1; if1.load_val = 4'd0;
        @(posedge clk); #1;
        checks++; if ({if1.busy, if1.pending} !== 5'd0) begin errors++; $display("FAIL load_zero: got busy=%b pending=%0d, expected 0/0", if1.busy, if1.pending); end
        if1.load = 1'b1; if1.load_val = 4'd2; if1.req = 1'b1;
        push_exp(1); push_exp(1);
        @(posedge clk); #1;
        if1.req = 1'b0;
        checks++; if (if1.pending !== 4'd2) begin errors++; $display("FAIL load_req_drop: got %0d, expected 2", if1.pending); end
        if1.load_val = 4'd9;
        @(posedge clk); #1;
        if1.load = 1'b0; if1.load_val = 4'd0;
        checks++; if (if1.pending !== 4'd1) begin errors++; $display("FAIL load_busy_ignored: got %0d, expected 1", if1.pending); end
        checks++; if (if1.inc !== 1'b1) begin errors++; $display("FAIL load_busy_inc: got %b, expected 1", if1.inc); end
        c = 0; dones = 0;
        while (c < 20) begin
            @(posedge clk); #1;
            if (if1.done === 1'b1) dones++;
            c++;
        end
        checks++; if (dones !== 1) begin errors++; $display("FAIL load_busy_done: got %0d, expected 1", dones); end
        checks++; if (if1.busy !== 1'b0) begin errors++; $display("FAIL load_busy_idle: got %b, expected 0", if1.busy); end
    endtask

    // rst during HIGH1 of a 4-pulse burst kills the partial pulse and everything queued.
    task automatic test_reset_mid_pulse();
        if1.load = 1'b1; if1.load_val = 4'd4;
        @(posedge clk); #1;
        if1.load = 1'b0; if1.load_val = 4'd0;
        checks++; if (if1.pending !== 4'd4) begin errors++; $display("FAIL rst_mid_load: got %0d, expected 4", if1.pending); end
        @(posedge clk); #1;
        checks++; if (if1.inc !== 1'b1) begin errors++; $display("FAIL rst_mid_high1: got %b, expected 1", if1.inc); end
        partial_ok[1] = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if ({if1.inc, if1.busy, if1.done} !== 3'b000) begin errors++; $display("FAIL rst_mid_out: got inc/busy/done=%b, expected 000", {if1.inc, if1.busy, if1.done}); end
        checks++; if (if1.pending !== 4'd0) begin errors++; $display("FAIL rst_mid_pending: got %0d, expected 0", if1.pending); end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            checks++; if ({if1.inc, if1.busy, if1.done} !== 3'b000) begin errors++; $display("FAIL rst_mid_after c%0d: got %b, expected 000", c, {if1.inc, if1.busy, if1.done}); end
        end
        partial_ok[1] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            pushed[i] = 0; seen[i] = 0; phase[i] = 0; partial_ok[i] = 1'b0;
        end
        rst = 1'b1;
        if0.req = 1'b0; if0.load = 1'b0; if0.load_val = '0; if0.clr_ovf = 1'b0;
        if1.req = 1'b0; if1.load = 1'b0; if1.load_val = '0; if1.clr_ovf = 1'b0;
        if2.req = 1'b0; if2.load = 1'b0; if2.load_val = '0; if2.clr_ovf = 1'b0;
        test_reset();
        test_single_req();
        test_burst_gap0();
        test_saturate();
        test_clr_ovf();
        test_load_busy();
        test_reset_mid_pulse();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sb_q[i].size() != 0) begin
                errors++;
                $display("FAIL sb_leftover[%0d]: got %0d pulses missing, expected 0", i, sb_q[i].size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
